// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ramp ADC sequencer.
//   state_t    : sequencer FSM states
//   *_DEF      : default parameter values used by the top and the interface
//   DAC_MAX    : full-scale DAC code for the default DAC width
//   CNT_W      : width of the shared settle/step down-counter for the defaults
//   cnt_width  : sizes the shared counter for any STEP_HOLD / SETTLE_CYCLES pair
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    RAMP   = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam int NUM_CH_DEF        = 4;
  localparam int CH_W_DEF          = 2;
  localparam int DAC_W_DEF         = 8;
  localparam int STEP_HOLD_DEF     = 256;
  localparam int SETTLE_CYCLES_DEF = 1024;

  localparam logic [DAC_W_DEF-1:0] DAC_MAX = {DAC_W_DEF{1'b1}};

  // Counter is loaded with (length - 1), so clog2 of the longer phase suffices.
  function automatic int cnt_width(input int step_hold, input int settle_cycles);
    int longest;
    longest = (step_hold > settle_cycles) ? step_hold : settle_cycles;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

  localparam int CNT_W = cnt_width(STEP_HOLD_DEF, SETTLE_CYCLES_DEF);

endpackage

// File: rtl/ramp_adc_sequencer_if.sv
// Result handshake bundle between the sequencer and its consumer.
//   result_valid : converted code available (master -> slave)
//   result_ready : consumer accepts the code (slave -> master)
//   result_data  : converted DAC code
//   result_ch    : analog channel the code belongs to
//   result_ovr   : comparator never tripped, input at or above full scale
interface ramp_adc_sequencer_if
  import adc_seq_pkg::*;
#(
  parameter int CH_W  = CH_W_DEF,
  parameter int DAC_W = DAC_W_DEF
);

  logic             result_valid;
  logic             result_ready;
  logic [DAC_W-1:0] result_data;
  logic [CH_W-1:0]  result_ch;
  logic             result_ovr;

  modport master (
    output result_valid,
    output result_data,
    output result_ch,
    output result_ovr,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_data,
    input  result_ch,
    input  result_ovr,
    output result_ready
  );

endinterface

// File: rtl/rr_next_channel.sv
// Round-robin channel picker (purely combinational).
//   mask        : per-channel enable
//   last_ch     : channel converted most recently
//   next_ch     : lowest enabled index strictly above last_ch, else lowest enabled index
//   any_enabled : at least one mask bit set
module rr_next_channel
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = CH_W_DEF
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   last_ch,
  output logic [CH_W-1:0]   next_ch,
  output logic              any_enabled
);

  logic            upper_hit_s;
  logic [CH_W-1:0] upper_idx_s;
  logic [CH_W-1:0] lowest_idx_s;

  // Scan from the top down so the lowest qualifying index is written last and wins.
  always_comb begin
    upper_hit_s  = 1'b0;
    upper_idx_s  = {CH_W{1'b0}};
    lowest_idx_s = {CH_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      lowest_idx_s = mask[i] ? CH_W'(i) : lowest_idx_s;
      upper_idx_s  = (mask[i] && (CH_W'(i) > last_ch)) ? CH_W'(i) : upper_idx_s;
      upper_hit_s  = (mask[i] && (CH_W'(i) > last_ch)) ? 1'b1 : upper_hit_s;
    end
    next_ch     = upper_hit_s ? upper_idx_s : lowest_idx_s;
    any_enabled = |mask;
  end

endmodule

// File: rtl/ramp_adc_sequencer.sv
// Ramp ADC sequencer: drives an external analog mux and a PWM DAC, ramps the DAC
// until the comparator trips and returns one code per enabled channel, round-robin.
//   clk, reset_n : system clock, asynchronous active-low reset
//   run          : level, 1 = keep converting, 0 = stop after the current conversion
//   ch_enable    : per-channel enable, sampled only when a channel is selected
//   compare_in   : raw comparator (1 = V_in > V_DAC), asynchronous to clk
//   mux_sel      : analog mux select
//   dac_duty     : PWM DAC duty code
//   busy         : high whenever the FSM is not IDLE
//   res          : result handshake (valid/ready, data, channel, overrange)
module ramp_adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH        = NUM_CH_DEF,
  parameter int CH_W          = CH_W_DEF,
  parameter int DAC_W         = DAC_W_DEF,
  parameter int STEP_HOLD     = STEP_HOLD_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic                compare_in,
  output logic [CH_W-1:0]     mux_sel,
  output logic [DAC_W-1:0]    dac_duty,
  output logic                busy,
  ramp_adc_sequencer_if.master res
);

  localparam int                CW          = cnt_width(STEP_HOLD, SETTLE_CYCLES);
  localparam logic [CW-1:0]     SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]     STEP_LOAD   = CW'(STEP_HOLD - 1);
  localparam logic [CW-1:0]     CNT_ZERO    = {CW{1'b0}};
  localparam logic [DAC_W-1:0]  CODE_ZERO   = {DAC_W{1'b0}};
  localparam logic [DAC_W-1:0]  CODE_MAX    = {DAC_W{1'b1}};
  localparam logic [CH_W-1:0]   LAST_RESET  = CH_W'(NUM_CH - 1);

  state_t           state_r,  state_next;
  logic [CW-1:0]    cnt_r,    cnt_next;
  logic [DAC_W-1:0] dac_r,    dac_next;
  logic [CH_W-1:0]  mux_r,    mux_next;
  logic [CH_W-1:0]  last_r,   last_next;
  logic             valid_r,  valid_next;
  logic [DAC_W-1:0] data_r,   data_next;
  logic [CH_W-1:0]  ch_r,     ch_next;
  logic             ovr_r,    ovr_next;
  logic             busy_r;

  logic             cmp_meta_r;
  logic             cmp_sync_r;
  logic             cmp_s;

  logic [CH_W-1:0]  rr_next_s;
  logic             rr_any_s;

  rr_next_channel #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr (
    .mask        (ch_enable),
    .last_ch     (last_r),
    .next_ch     (rr_next_s),
    .any_enabled (rr_any_s)
  );

  // Two-flop synchronizer for the asynchronous comparator pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_meta_r <= 1'b0;
      cmp_sync_r <= 1'b0;
    end else begin
      cmp_meta_r <= compare_in;
      cmp_sync_r <= cmp_meta_r;
    end
  end

  assign cmp_s = cmp_sync_r;

  // Next-state and next-output logic; the shared counter times both settle and step hold.
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    dac_next   = dac_r;
    mux_next   = mux_r;
    last_next  = last_r;
    valid_next = valid_r;
    data_next  = data_r;
    ch_next    = ch_r;
    ovr_next   = ovr_r;

    case (state_r)
      IDLE: begin
        if (run && rr_any_s) begin
          state_next = SELECT;
          mux_next   = rr_next_s;
          last_next  = rr_next_s;
          dac_next   = CODE_ZERO;
          cnt_next   = SETTLE_LOAD;
        end else begin
          state_next = IDLE;
        end
      end

      SELECT: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_next = cnt_r - CW'(1);
        end else begin
          state_next = RAMP;
          cnt_next   = STEP_LOAD;
          dac_next   = CODE_ZERO;
        end
      end

      RAMP: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_next = cnt_r - CW'(1);
        end else if (!cmp_s) begin
          // Comparator tripped at the end of this hold: current code is the result.
          state_next = RESULT;
          valid_next = 1'b1;
          data_next  = dac_r;
          ch_next    = last_r;
          ovr_next   = 1'b0;
          dac_next   = CODE_ZERO;
        end else if (dac_r != CODE_MAX) begin
          dac_next = dac_r + DAC_W'(1);
          cnt_next = STEP_LOAD;
        end else begin
          // Full scale reached without a trip; saturate instead of wrapping.
          state_next = RESULT;
          valid_next = 1'b1;
          data_next  = CODE_MAX;
          ch_next    = last_r;
          ovr_next   = 1'b1;
          dac_next   = CODE_ZERO;
        end
      end

      RESULT: begin
        if (valid_r && res.result_ready) begin
          valid_next = 1'b0;
          if (run && rr_any_s) begin
            state_next = SELECT;
            mux_next   = rr_next_s;
            last_next  = rr_next_s;
            dac_next   = CODE_ZERO;
            cnt_next   = SETTLE_LOAD;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = RESULT;
        end
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        dac_next   = CODE_ZERO;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers; reset drops any conversion in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      dac_r   <= CODE_ZERO;
      mux_r   <= {CH_W{1'b0}};
      last_r  <= LAST_RESET;
      valid_r <= 1'b0;
      data_r  <= CODE_ZERO;
      ch_r    <= {CH_W{1'b0}};
      ovr_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
      dac_r   <= dac_next;
      mux_r   <= mux_next;
      last_r  <= last_next;
      valid_r <= valid_next;
      data_r  <= data_next;
      ch_r    <= ch_next;
      ovr_r   <= ovr_next;
      busy_r  <= (state_next != IDLE);
    end
  end

  assign mux_sel          = mux_r;
  assign dac_duty         = dac_r;
  assign busy             = busy_r;
  assign res.result_valid = valid_r;
  assign res.result_data  = data_r;
  assign res.result_ch    = ch_r;
  assign res.result_ovr   = ovr_r;

endmodule
